// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: Funct3 encodings, port ids, response pipe entry.
// Pure declarations; no timing or flow-control behaviour of its own.
package dmem_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } funct3_e;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_LDR = 1'b1
    } port_e;

    typedef struct packed {
        logic       vld;
        port_e      port;
        logic       we;
        logic [2:0] funct3;
        logic [1:0] lo;
        logic       err;
    } dmem_rsp_t;

    // 011, 110 and 111 have no load or store meaning in either direction.
    function automatic logic f3_illegal(input logic [2:0] f);
        return (f == 3'b011) || (f == 3'b110) || (f == 3'b111);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU port, loader port and memory-macro signals around the arbiter.
// The slave side is the arbiter; the master side is the requesters plus the memory.
interface dmem_arbiter_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
);
    logic                  c_req;
    logic                  c_we;
    logic [DM_ADDRESS-1:0] c_addr;
    logic [DATA_W-1:0]     c_wdata;
    logic [2:0]            c_funct3;
    logic                  c_gnt;
    logic                  c_done;
    logic [DATA_W-1:0]     c_rdata;
    logic                  c_err;

    logic                  d_req;
    logic                  d_we;
    logic [DM_ADDRESS-1:0] d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic                  d_gnt;
    logic                  d_done;
    logic [DATA_W-1:0]     d_rdata;
    logic                  d_err;

    logic [31:0]           m_raddr;
    logic [31:0]           m_waddr;
    logic [31:0]           m_wdata;
    logic [3:0]            m_wr;
    logic [31:0]           m_rdata;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata, c_funct3,
        output c_gnt, c_done, c_rdata, c_err,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_done, d_rdata, d_err,
        output m_raddr, m_waddr, m_wdata, m_wr,
        input  m_rdata
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata, c_funct3,
        input  c_gnt, c_done, c_rdata, c_err,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_done, d_rdata, d_err,
        input  m_raddr, m_waddr, m_wdata, m_wr,
        output m_rdata
    );

endinterface

// File: rtl/dmem_lane_fmt.sv
// Funct3 lane formatter: byte enables, replicated store data, alignment error, load extension.
// Purely combinational, zero latency, no flow control.
module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lo,
    input  logic        we,
    input  logic [31:0] wd,
    input  logic [31:0] raw,
    output logic [3:0]  wr,
    output logic [31:0] wdata,
    output logic        err,
    output logic [31:0] rdata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        err   = f3_illegal(funct3);
        wr    = 4'b0000;
        wdata = wd;
        // Bits [1:0] carry the access size for both loads and stores.
        case (funct3[1:0])
            2'b00: begin
                wdata = {4{wd[7:0]}};
                wr    = 4'b0001 << lo;
            end
            2'b01: begin
                err   = err | lo[0];
                wdata = {2{wd[15:0]}};
                wr    = lo[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                err   = err | (lo != 2'b00);
                wr    = 4'b1111;
            end
        endcase
        if (!we || err) begin
            wr = 4'b0000;
        end
    end

    always_comb begin
        byte_sel = raw[7:0];
        case (lo)
            2'b00:   byte_sel = raw[7:0];
            2'b01:   byte_sel = raw[15:8];
            2'b10:   byte_sel = raw[23:16];
            default: byte_sel = raw[31:24];
        endcase
        half_sel = lo[1] ? raw[31:16] : raw[15:0];

        rdata = 32'h0;
        case (funct3)
            LB:      rdata = {{24{byte_sel[7]}}, byte_sel};
            LH:      rdata = {{16{half_sel[15]}}, half_sel};
            LW:      rdata = raw;
            LBU:     rdata = {24'h0, byte_sel};
            LHU:     rdata = {16'h0, half_sel};
            default: rdata = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter between CPU and loader in front of the byte-enabled data memory.
// Grant is combinational; done/rdata/err follow exactly one cycle later; a losing request must be held.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    port_e                 last;
    logic [DM_ADDRESS-1:0] hold_addr;
    dmem_rsp_t             rsp;

    logic                  c_win;
    logic                  c_gnt;
    logic                  d_gnt;
    logic                  any_gnt;
    logic                  sel_we;
    logic [DM_ADDRESS-1:0] sel_addr;
    logic [31:0]           sel_wd;
    logic [2:0]            sel_f3;

    logic [3:0]            req_wr;
    logic [31:0]           req_wdata;
    logic                  req_err;
    logic [31:0]           req_unused_rdata;

    logic [3:0]            rsp_unused_wr;
    logic [31:0]           rsp_unused_wdata;
    logic                  rsp_unused_err;
    logic [DATA_W-1:0]     rsp_rdata;
    logic [DATA_W-1:0]     load_data;
    logic                  done_ok;

    // CPU wins a contest only when the loader held the previous grant.
    assign c_win   = bus.c_req && (!bus.d_req || (last == PORT_LDR));
    assign c_gnt   = !reset && c_win;
    assign d_gnt   = !reset && bus.d_req && !c_win;
    assign any_gnt = c_gnt || d_gnt;

    always_comb begin
        sel_we   = bus.c_we;
        sel_addr = bus.c_addr;
        sel_wd   = bus.c_wdata;
        sel_f3   = bus.c_funct3;
        if (!c_win) begin
            sel_we   = bus.d_we;
            sel_addr = bus.d_addr;
            sel_wd   = bus.d_wdata;
            sel_f3   = LW;
        end
    end

    dmem_lane_fmt u_req_fmt (
        .funct3 (sel_f3),
        .lo     (sel_addr[1:0]),
        .we     (sel_we),
        .wd     (sel_wd),
        .raw    (32'h0),
        .wr     (req_wr),
        .wdata  (req_wdata),
        .err    (req_err),
        .rdata  (req_unused_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            last      <= PORT_LDR;
            hold_addr <= '0;
            rsp       <= '0;
        end else begin
            rsp.vld    <= any_gnt;
            rsp.port   <= d_gnt ? PORT_LDR : PORT_CPU;
            rsp.we     <= sel_we;
            rsp.funct3 <= sel_f3;
            rsp.lo     <= sel_addr[1:0];
            rsp.err    <= req_err;
            if (any_gnt) begin
                last      <= d_gnt ? PORT_LDR : PORT_CPU;
                hold_addr <= sel_addr;
            end
        end
    end

    assign bus.c_gnt   = c_gnt;
    assign bus.d_gnt   = d_gnt;
    assign bus.m_wr    = any_gnt ? req_wr : 4'b0000;
    assign bus.m_wdata = any_gnt ? req_wdata : 32'h0;

    // Idle cycles keep presenting the last granted address.
    always_comb begin
        bus.m_raddr = 32'h0;
        if (!reset) begin
            bus.m_raddr = {{(32-DM_ADDRESS){1'b0}}, (any_gnt ? sel_addr : hold_addr)};
        end
        bus.m_waddr = {bus.m_raddr[31:2], 2'b00};
    end

    dmem_lane_fmt u_rsp_fmt (
        .funct3 (rsp.funct3),
        .lo     (rsp.lo),
        .we     (rsp.we),
        .wd     (32'h0),
        .raw    (bus.m_rdata),
        .wr     (rsp_unused_wr),
        .wdata  (rsp_unused_wdata),
        .err    (rsp_unused_err),
        .rdata  (rsp_rdata)
    );

    assign done_ok   = rsp.vld && !reset;
    assign load_data = (rsp.we || rsp.err) ? '0 : rsp_rdata;

    assign bus.c_done  = done_ok && (rsp.port == PORT_CPU);
    assign bus.d_done  = done_ok && (rsp.port == PORT_LDR);
    assign bus.c_err   = bus.c_done && rsp.err;
    assign bus.d_err   = bus.d_done && rsp.err;
    assign bus.c_rdata = bus.c_done ? load_data : '0;
    assign bus.d_rdata = bus.d_done ? load_data : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: byte-level memory model, per-cycle compare, literal pins.
module tb_dmem_arbiter;

    logic clk;
    logic reset;

    dmem_arbiter_if #(.DM_ADDRESS(9), .DATA_W(32)) bus ();

    dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory macro: write on negedge, synchronous read on posedge.
    logic [31:0] macro [128];

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (bus.m_wr[k]) macro[bus.m_waddr[8:2]][k*8 +: 8] <= bus.m_wdata[k*8 +: 8];
        end
    end

    always @(posedge clk) bus.m_rdata <= macro[bus.m_raddr[8:2]];

    int checks;
    int failures;

    // Reference model state: byte-addressed memory, round-robin owner, pending completion.
    logic [7:0]  mm [512];
    int          m_last;
    logic [8:0]  m_hold;
    bit          pend_vld;
    int          pend_port;
    bit          pend_err;
    logic [31:0] pend_rdata;

    // Observations used by the literal pins.
    logic [31:0] obs_c_rdata;
    logic [31:0] obs_d_rdata;
    logic [3:0]  obs_wr;
    logic [31:0] obs_wdata;
    logic [7:0]  gnt_hist;
    int          c_err_cnt;
    int          d_err_cnt;
    logic        obs_cdone_rst;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step(input bit rst,
                        input bit creq, input bit cwe, input logic [8:0] caddr,
                        input logic [31:0] cwd, input logic [2:0] cf3,
                        input bit dreq, input bit dwe, input logic [8:0] daddr,
                        input logic [31:0] dwd);
        int          win;
        bit          we;
        logic [8:0]  a;
        logic [31:0] wd;
        logic [2:0]  f3;
        int          nb;
        bit          err;
        logic [31:0] val;
        bit          e_cg, e_dg, e_cd, e_dd, e_ce, e_de;
        logic [31:0] e_cr, e_dr, e_raddr, e_wdata;
        logic [3:0]  e_wr;
        bit          chk_wdata;
        bit          n_vld;
        int          n_port;
        bit          n_err;
        logic [31:0] n_rdata;

        #1;
        reset        = rst;
        bus.c_req    = creq;
        bus.c_we     = cwe;
        bus.c_addr   = caddr;
        bus.c_wdata  = cwd;
        bus.c_funct3 = cf3;
        bus.d_req    = dreq;
        bus.d_we     = dwe;
        bus.d_addr   = daddr;
        bus.d_wdata  = dwd;

        e_cg = 0; e_dg = 0; e_cd = 0; e_dd = 0; e_ce = 0; e_de = 0;
        e_cr = 0; e_dr = 0; e_raddr = 0; e_wdata = 0; e_wr = 0; chk_wdata = 1;
        n_vld = 0; n_port = 0; n_err = 0; n_rdata = 0;
        win = -1;

        if (!rst) begin
            if (pend_vld && pend_port == 0) begin
                e_cd = 1; e_ce = pend_err; e_cr = pend_rdata;
            end
            if (pend_vld && pend_port == 1) begin
                e_dd = 1; e_de = pend_err; e_dr = pend_rdata;
            end
            if (creq && dreq) win = (m_last == 1) ? 0 : 1;
            else if (creq)    win = 0;
            else if (dreq)    win = 1;

            if (win >= 0) begin
                e_cg = (win == 0);
                e_dg = (win == 1);
                we = (win == 0) ? cwe   : dwe;
                a  = (win == 0) ? caddr : daddr;
                wd = (win == 0) ? cwd   : dwd;
                f3 = (win == 0) ? cf3   : 3'b010;
                nb = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
                err = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || ((int'(a) % nb) != 0);
                e_raddr = {23'h0, a};
                val = 0;
                if (we) begin
                    chk_wdata = !err;
                    if (!err) begin
                        e_wr = 4'((1 << nb) - 1) << a[1:0];
                        e_wdata = (nb == 1) ? {4{wd[7:0]}} : (nb == 2) ? {2{wd[15:0]}} : wd;
                        for (int i = 0; i < nb; i++) mm[int'(a) + i] = wd[i*8 +: 8];
                    end
                end else begin
                    chk_wdata = 0;
                    if (!err) begin
                        for (int i = 0; i < nb; i++) val[i*8 +: 8] = mm[int'(a) + i];
                        if (!f3[2] && nb == 1 && val[7])  val[31:8]  = 24'hFFFFFF;
                        if (!f3[2] && nb == 2 && val[15]) val[31:16] = 16'hFFFF;
                    end
                end
                n_vld = 1; n_port = win; n_err = err; n_rdata = val;
            end else begin
                e_raddr = {23'h0, m_hold};
            end
        end

        #3;
        chk("c_gnt",   {31'h0, bus.c_gnt},  {31'h0, e_cg});
        chk("d_gnt",   {31'h0, bus.d_gnt},  {31'h0, e_dg});
        chk("c_done",  {31'h0, bus.c_done}, {31'h0, e_cd});
        chk("d_done",  {31'h0, bus.d_done}, {31'h0, e_dd});
        chk("c_err",   {31'h0, bus.c_err},  {31'h0, e_ce});
        chk("d_err",   {31'h0, bus.d_err},  {31'h0, e_de});
        chk("c_rdata", bus.c_rdata, e_cr);
        chk("d_rdata", bus.d_rdata, e_dr);
        chk("m_wr",    {28'h0, bus.m_wr}, {28'h0, e_wr});
        chk("m_raddr", bus.m_raddr, e_raddr);
        chk("m_waddr", bus.m_waddr, {e_raddr[31:2], 2'b00});
        if (chk_wdata) chk("m_wdata", bus.m_wdata, e_wdata);

        if (bus.c_done) obs_c_rdata = bus.c_rdata;
        if (bus.d_done) obs_d_rdata = bus.d_rdata;
        if (bus.m_wr != 4'b0000) begin
            obs_wr    = bus.m_wr;
            obs_wdata = bus.m_wdata;
        end
        if (bus.c_err) c_err_cnt++;
        if (bus.d_err) d_err_cnt++;
        if (rst) obs_cdone_rst = bus.c_done;
        gnt_hist = {gnt_hist[5:0], bus.c_gnt, bus.d_gnt};

        if (rst) begin
            m_last = 1; m_hold = 0; pend_vld = 0;
        end else begin
            if (win >= 0) begin
                m_last = win; m_hold = a;
            end
            pend_vld = n_vld; pend_port = n_port; pend_err = n_err; pend_rdata = n_rdata;
        end
        @(posedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 9'h0, 32'h0, 3'b000, 0, 0, 9'h0, 32'h0);
    endtask

    task automatic cpu(input bit we, input logic [8:0] a, input logic [31:0] wd, input logic [2:0] f3);
        step(0, 1, we, a, wd, f3, 0, 0, 9'h0, 32'h0);
    endtask

    task automatic ldr(input bit we, input logic [8:0] a, input logic [31:0] wd);
        step(0, 0, 0, 9'h0, 32'h0, 3'b000, 1, we, a, wd);
    endtask

    initial begin
        checks = 0; failures = 0;
        m_last = 1; m_hold = 0; pend_vld = 0; pend_port = 0; pend_err = 0; pend_rdata = 0;
        obs_c_rdata = 0; obs_d_rdata = 0; obs_wr = 0; obs_wdata = 0; gnt_hist = 0;
        c_err_cnt = 0; d_err_cnt = 0; obs_cdone_rst = 1'bx;
        for (int k = 0; k < 512; k++) mm[k] = 8'(k) ^ 8'h5A;
        for (int w = 0; w < 128; w++)
            for (int b = 0; b < 4; b++) macro[w][b*8 +: 8] = 8'(w*4 + b) ^ 8'h5A;
        bus.m_rdata = 32'h0;
        reset = 1'b1;
        bus.c_req = 0; bus.c_we = 0; bus.c_addr = 0; bus.c_wdata = 0; bus.c_funct3 = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
        @(posedge clk);

        step(1, 0, 0, 9'h0, 32'h0, 3'b000, 0, 0, 9'h0, 32'h0);
        repeat (3) idle();

        // Byte store then signed/unsigned byte loads, back to back.
        cpu(1, 9'h006, 32'h000000A5, 3'b000);
        chk("lit_sb_wr", {28'h0, obs_wr}, 32'h00000004);
        chk("lit_sb_wdata", obs_wdata, 32'hA5A5A5A5);
        cpu(0, 9'h006, 32'h0, 3'b000);
        cpu(0, 9'h006, 32'h0, 3'b100);
        chk("lit_lb", obs_c_rdata, 32'hFFFFFFA5);
        idle();
        chk("lit_lbu", obs_c_rdata, 32'h000000A5);

        // Half store, signed half load, then the containing word.
        cpu(1, 9'h00A, 32'h00008001, 3'b001);
        chk("lit_sh_wr", {28'h0, obs_wr}, 32'h0000000C);
        cpu(0, 9'h00A, 32'h0, 3'b001);
        cpu(0, 9'h008, 32'h0, 3'b010);
        chk("lit_lh", obs_c_rdata, 32'hFFFF8001);
        idle();
        chk("lit_lw", obs_c_rdata, 32'h80015352);

        // Loader-only access leaves the loader as last owner, so the CPU wins next.
        ldr(0, 9'h040, 32'h0);
        idle();
        gnt_hist = 0;
        step(0, 1, 0, 9'h010, 32'h0, 3'b010, 1, 1, 9'h020, 32'hDEADBEEF);
        step(0, 1, 0, 9'h010, 32'h0, 3'b010, 1, 1, 9'h020, 32'hDEADBEEF);
        step(0, 1, 0, 9'h020, 32'h0, 3'b010, 1, 0, 9'h010, 32'h0);
        step(0, 1, 0, 9'h020, 32'h0, 3'b010, 1, 0, 9'h010, 32'h0);
        chk("lit_rr_order", {24'h0, gnt_hist}, 32'h00000099);
        chk("lit_cross_port_rd", obs_c_rdata, 32'hDEADBEEF);
        idle();
        chk("lit_ldr_lw", obs_d_rdata, 32'h49484B4A);

        // Misaligned and illegal accesses: error completions, no writes.
        obs_wr = 0;
        c_err_cnt = 0;
        cpu(0, 9'h002, 32'h0, 3'b010);
        cpu(1, 9'h003, 32'h0000FFFF, 3'b001);
        cpu(0, 9'h000, 32'h0, 3'b111);
        ldr(1, 9'h021, 32'h12345678);
        idle();
        chk("lit_err_cnt", c_err_cnt, 3);
        chk("lit_ldr_err_cnt", d_err_cnt, 1);
        chk("lit_err_no_write", {28'h0, obs_wr}, 32'h0);

        // Reset right after a CPU grant swallows its completion and rearms the pointer.
        cpu(0, 9'h010, 32'h0, 3'b010);
        step(1, 1, 0, 9'h010, 32'h0, 3'b010, 0, 0, 9'h0, 32'h0);
        chk("lit_rst_no_done", {31'h0, obs_cdone_rst}, 32'h0);
        gnt_hist = 0;
        step(0, 1, 0, 9'h014, 32'h0, 3'b010, 1, 0, 9'h018, 32'h0);
        chk("lit_rst_cpu_first", {24'h0, gnt_hist}, 32'h00000002);
        step(0, 0, 0, 9'h0, 32'h0, 3'b000, 1, 0, 9'h018, 32'h0);
        repeat (2) idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
